// File: rtl/imem_loader.sv
// Byte-stream instruction RAM loader: packs bytes little-endian into words, writes them from
// address 0 and holds the core in reset until the image is in. LOADER_CHECKSUM_EN adds a checksum byte.
module imem_loader #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            in_data_i,
    output logic                  in_ready_o,
    output logic                  ram_wen_o,
    output logic [ADDR_WIDTH-1:0] ram_waddr_o,
    output logic [DATA_WIDTH-1:0] ram_wdata_o,
    output logic                  core_rst_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  csum_err_o
);
    localparam int BYTES = DATA_WIDTH / 8;
    localparam int BW    = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RECV,
        S_WRITE,
`ifdef LOADER_CHECKSUM_EN
        S_CHECK,
`endif
        S_DONE
    } state_e;

    state_e                  state_q, state_d, after_last;
    logic [BW-1:0]           byte_cnt_q, byte_cnt_d;
    logic [ADDR_WIDTH:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_WIDTH:0]     len_q, len_d, len_clamped;
    logic [DATA_WIDTH-1:0]   word_q, word_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic                    in_ready_q, ram_wen_q, core_rst_q, busy_q, done_q;
    logic                    csum_err_q, csum_err_d;
    logic                    accept;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]              csum_q, csum_d;
`endif

    assign accept      = in_valid_i && in_ready_q;
    assign len_clamped = (len_i > DEPTH) ? DEPTH : len_i;
`ifdef LOADER_CHECKSUM_EN
    assign after_last  = S_CHECK;
`else
    assign after_last  = S_DONE;
`endif

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_cnt_d = word_cnt_q;
        len_d      = len_q;
        word_d     = word_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;
        csum_err_d = csum_err_q;
`ifdef LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    len_d      = len_clamped;
                    byte_cnt_d = '0;
                    word_cnt_d = '0;
                    word_d     = '0;
                    waddr_d    = '0;
                    csum_err_d = 1'b0;
`ifdef LOADER_CHECKSUM_EN
                    csum_d     = 8'h00;
`endif
                    state_d    = (len_clamped == '0) ? after_last : S_RECV;
                end
            end
            S_RECV: begin
                if (accept) begin
                    word_d[8*byte_cnt_q +: 8] = in_data_i;
`ifdef LOADER_CHECKSUM_EN
                    csum_d = csum_q + in_data_i;
`endif
                    if (byte_cnt_q == BW'(BYTES - 1)) begin
                        byte_cnt_d = '0;
                        wdata_d    = word_d;
                        waddr_d    = word_cnt_q[ADDR_WIDTH-1:0];
                        state_d    = S_WRITE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
            end
            S_WRITE: begin
                word_cnt_d = word_cnt_q + 1'b1;
                state_d    = (word_cnt_d == len_q) ? after_last : S_RECV;
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHECK: begin
                if (accept) begin
                    csum_err_d = (in_data_i != csum_q);
                    state_d    = S_DONE;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
            word_q     <= '0;
            waddr_q    <= '0;
            wdata_q    <= '0;
            in_ready_q <= 1'b0;
            ram_wen_q  <= 1'b0;
            core_rst_q <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            csum_err_q <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'h00;
`endif
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_cnt_q <= word_cnt_d;
            len_q      <= len_d;
            word_q     <= word_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
            in_ready_q <= (state_d == S_RECV) || (state_d == S_CHECK);
            busy_q     <= (state_d == S_RECV) || (state_d == S_WRITE) || (state_d == S_CHECK);
`else
            in_ready_q <= (state_d == S_RECV);
            busy_q     <= (state_d == S_RECV) || (state_d == S_WRITE);
`endif
            ram_wen_q  <= (state_d == S_WRITE);
            core_rst_q <= (state_d != S_DONE);
            done_q     <= (state_d == S_DONE);
            csum_err_q <= csum_err_d;
        end
    end

    assign in_ready_o  = in_ready_q;
    assign ram_wen_o   = ram_wen_q;
    assign ram_waddr_o = waddr_q;
    assign ram_wdata_o = wdata_q;
    assign core_rst_o  = core_rst_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign csum_err_o  = csum_err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboard bench for imem_loader: expected RAM writes are queued by the stimulus and
// checked by a write monitor; LOADER_CHECKSUM_EN builds also exercise the checksum byte.
module tb_imem_loader;
    localparam int AW = 5;
    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW:0]   len = '0;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready, ram_wen, core_rst, busy, done, csum_err;
    logic [AW-1:0] ram_waddr;
    logic [DW-1:0] ram_wdata;

    int checks = 0;
    int errors = 0;
    int wr_cnt = 0;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;
    exp_t exp_q[$];

    imem_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start), .len_i(len),
        .in_valid_i(in_valid), .in_data_i(in_data), .in_ready_o(in_ready),
        .ram_wen_o(ram_wen), .ram_waddr_o(ram_waddr), .ram_wdata_o(ram_wdata),
        .core_rst_o(core_rst), .busy_o(busy), .done_o(done), .csum_err_o(csum_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (ram_wen === 1'b1) begin
            wr_cnt++;
            chk("in_ready_during_write", 64'(in_ready), 64'(0));
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data %h, expected no write", ram_waddr, ram_wdata);
            end else begin
                e = exp_q.pop_front();
                chk("waddr", 64'(ram_waddr), 64'(e.addr));
                chk("wdata", ram_wdata, e.data);
            end
        end
    end

    task automatic push_exp(input int addr, input logic [DW-1:0] data);
        exp_t e;
        e.addr = AW'(addr);
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic start_load(input int l);
        start = 1'b1;
        len   = (AW+1)'(l);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (in_ready !== 1'b1 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: in_ready %b, expected 1", in_ready);
            in_valid = 1'b0;
            return;
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int t = 0;
        while (done !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk("done_reached", 64'(done), 64'(1));
    endtask

    task automatic check_finished(input logic err_exp);
        chk("core_rst_released", 64'(core_rst), 64'(0));
        chk("busy_clear", 64'(busy), 64'(0));
        chk("csum_err", 64'(csum_err), 64'(err_exp));
    endtask

    task automatic check_reset_vals();
        chk("rst_in_ready", 64'(in_ready), 64'(0));
        chk("rst_ram_wen", 64'(ram_wen), 64'(0));
        chk("rst_waddr", 64'(ram_waddr), 64'(0));
        chk("rst_wdata", ram_wdata, 64'(0));
        chk("rst_core_rst", 64'(core_rst), 64'(1));
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_csum_err", 64'(csum_err), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog timeout");
    end

    initial begin
        int wr0;
        logic [DW-1:0] d;

        repeat (3) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);

        // len=1, bytes 01..08
        push_exp(0, 64'h0807060504030201);
        wr0 = wr_cnt;
        start_load(1);
        chk("recv_busy", 64'(busy), 64'(1));
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h24);
`endif
        wait_done();
        check_finished(1'b0);
        chk("t1_writes", 64'(wr_cnt - wr0), 64'(1));

        // len=2, in_valid gapped; restart directly from DONE
        push_exp(0, 64'h1817161514131211);
        push_exp(1, 64'h2827262524232221);
        wr0 = wr_cnt;
        start_load(2);
        chk("restart_done_clear", 64'(done), 64'(0));
        chk("restart_core_rst", 64'(core_rst), 64'(1));
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(((i / 8) + 1) * 16 + (i % 8) + 1));
            @(negedge clk);
        end
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'hC8);
`endif
        wait_done();
        check_finished(1'b0);
        chk("t2_writes", 64'(wr_cnt - wr0), 64'(2));

        // len=0
        wr0 = wr_cnt;
        start_load(0);
`ifdef LOADER_CHECKSUM_EN
        chk("len0_check_busy", 64'(busy), 64'(1));
        send_byte(8'h00);
        wait_done();
        check_finished(1'b0);
`else
        @(negedge clk);
        chk("len0_done", 64'(done), 64'(1));
        check_finished(1'b0);
`endif
        chk("len0_writes", 64'(wr_cnt - wr0), 64'(0));

        // rst after 3 bytes, then a clean len=1 load
        wr0 = wr_cnt;
        start_load(1);
        for (int i = 0; i < 3; i++) send_byte(8'hE0 + 8'(i));
        rst = 1'b1;
        @(negedge clk);
        check_reset_vals();
        rst = 1'b0;
        @(negedge clk);
        chk("abort_writes", 64'(wr_cnt - wr0), 64'(0));
        push_exp(0, 64'hA7A6A5A4A3A2A1A0);
        start_load(1);
        for (int i = 0; i < 8; i++) send_byte(8'hA0 + 8'(i));
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h1C);
`endif
        wait_done();
        check_finished(1'b0);
        chk("t4_writes", 64'(wr_cnt - wr0), 64'(1));

        // len=40 clamps to 32 words
        for (int w = 0; w < 32; w++) begin
            for (int k = 0; k < 8; k++) d[8*k +: 8] = 8'(8 * w + k);
            push_exp(w, d);
        end
        wr0 = wr_cnt;
        start_load(40);
        for (int i = 0; i < 256; i++) send_byte(8'(i));
`ifdef LOADER_CHECKSUM_EN
        send_byte(8'h80);
`endif
        wait_done();
        check_finished(1'b0);
        chk("clamp_writes", 64'(wr_cnt - wr0), 64'(32));
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("overrun_in_ready", 64'(in_ready), 64'(0));
        end
        in_valid = 1'b0;
        chk("overrun_writes", 64'(wr_cnt - wr0), 64'(32));

`ifdef LOADER_CHECKSUM_EN
        // wrong checksum
        push_exp(0, 64'h0807060504030201);
        start_load(1);
        for (int i = 1; i <= 8; i++) send_byte(8'(i));
        send_byte(8'h25);
        wait_done();
        check_finished(1'b1);
`endif

        repeat (3) @(negedge clk);
        chk("scoreboard_empty", 64'(exp_q.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
